// File: rtl/vec_asip_pkg.sv
// Shared types, sizes and register-index decode for the vector execute stage.
package vec_asip_pkg;
  localparam int REG_SIZE = 8;
  localparam int VEC_SIZE = 4;
  localparam int SEL_BITS = 4;
  localparam int REG_QTY  = 4;
  localparam int VEC_W    = REG_SIZE * VEC_SIZE;
  localparam int SH_W     = $clog2(REG_SIZE);
  localparam int CNT_W    = $clog2(REG_SIZE);

  typedef logic [REG_SIZE-1:0] lane_t;
  typedef logic [VEC_W-1:0]    vec_t;
  typedef logic [SEL_BITS-1:0] reg_idx_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLL = 3'd5,
    OP_SRL = 3'd6,
    OP_MUL = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  localparam reg_idx_t          SC_BASE  = reg_idx_t'(REG_QTY);
  localparam reg_idx_t          SC_END   = reg_idx_t'(2 * REG_QTY);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REG_SIZE - 1);

  function automatic logic isVecReg(reg_idx_t idx);
    return idx < SC_BASE;
  endfunction

  // Indices at or above SC_END are special/read-only and never strobed.
  function automatic logic isScReg(reg_idx_t idx);
    return (idx >= SC_BASE) && (idx < SC_END);
  endfunction
endpackage

// File: rtl/vec_lane_alu.sv
// Single-lane combinational ALU for the one-cycle ops; MUL is handled iteratively in the top.
module vec_lane_alu
  import vec_asip_pkg::*;
(
  input  op_e   op_i,
  input  lane_t a_i,
  input  lane_t b_i,
  output lane_t y_o
);
  logic [SH_W-1:0] shamt;
  assign shamt = b_i[SH_W-1:0];

  always_comb begin
    y_o = '0;
    unique case (op_i)
      OP_ADD:  y_o = a_i + b_i;
      OP_SUB:  y_o = a_i - b_i;
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_SLL:  y_o = a_i << shamt;
      OP_SRL:  y_o = a_i >> shamt;
      default: y_o = '0;
    endcase
  end
endmodule

// File: rtl/vec_execute_stage.sv
// Vector execute stage feeding the regFile write port: one-cycle lane ops plus
// an iterative shift-add multiply that stalls upstream via inReady.
module vec_execute_stage
  import vec_asip_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                inValid,
  output logic                inReady,
  input  logic [2:0]          opcode,
  input  logic [VEC_W-1:0]    operand1,
  input  logic [VEC_W-1:0]    operand2,
  input  logic [SEL_BITS-1:0] destReg,
  output logic [VEC_W-1:0]    dataIn,
  output logic [SEL_BITS-1:0] regToWrite,
  output logic                regWrEnVec,
  output logic                regWrEnSc,
  output logic                busy,
  output state_e              stateDbg
);
  // Handshake: an instruction is taken on a rising edge where inValid && inReady;
  // upstream holds it while inReady is low, and inValid then is ignored.
  state_e         state_q, state_d;
  reg_idx_t       dest_q;
  logic [CNT_W-1:0] cnt_q;
  vec_t           data_q;
  reg_idx_t       wr_reg_q;
  logic           wr_vec_q, wr_sc_q;

  op_e      op;
  logic     accept, is_mul, mul_start, mul_done, wr_load;
  vec_t     alu_res, mul_res, wr_data;
  reg_idx_t wr_dest;

  assign op        = op_e'(opcode);
  assign inReady   = (state_q != ST_MUL);
  assign busy      = (state_q == ST_MUL);
  assign accept    = inValid && inReady;
  assign is_mul    = (op == OP_MUL);
  assign mul_start = accept && is_mul;

  always_comb begin
    state_d  = state_q;
    mul_done = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_WB: begin
        if (accept) state_d = is_mul ? ST_MUL : ST_WB;
        else        state_d = ST_IDLE;
      end
      ST_MUL: begin
        if (cnt_q == CNT_LAST) begin
          state_d  = ST_WB;
          mul_done = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wr_load = (accept && !is_mul) || mul_done;
  assign wr_dest = mul_done ? dest_q : destReg;
  assign wr_data = mul_done ? mul_res : alu_res;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      dest_q   <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      wr_reg_q <= '0;
      wr_vec_q <= 1'b0;
      wr_sc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (wr_load) begin
        data_q   <= wr_data;
        wr_reg_q <= wr_dest;
        wr_vec_q <= isVecReg(wr_dest);
        wr_sc_q  <= isScReg(wr_dest);
      end else begin
        wr_vec_q <= 1'b0;
        wr_sc_q  <= 1'b0;
      end
      if (mul_start) begin
        dest_q <= destReg;
        cnt_q  <= '0;
      end else if (state_q == ST_MUL) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Per-lane datapath: the last shift-add step's sum is captured directly as the result.
  for (genvar l = 0; l < VEC_SIZE; l++) begin : g_lane
    lane_t a_l, b_l, alu_y, step_acc;
    lane_t mcand_q, mplier_q, acc_q;

    assign a_l = operand1[l*REG_SIZE +: REG_SIZE];
    assign b_l = operand2[l*REG_SIZE +: REG_SIZE];

    vec_lane_alu u_alu (
      .op_i (op),
      .a_i  (a_l),
      .b_i  (b_l),
      .y_o  (alu_y)
    );

    assign step_acc = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign alu_res[l*REG_SIZE +: REG_SIZE] = alu_y;
    assign mul_res[l*REG_SIZE +: REG_SIZE] = step_acc;

    always_ff @(posedge clk) begin
      if (reset) begin
        mcand_q  <= '0;
        mplier_q <= '0;
        acc_q    <= '0;
      end else if (mul_start) begin
        mcand_q  <= a_l;
        mplier_q <= b_l;
        acc_q    <= '0;
      end else if (state_q == ST_MUL) begin
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        acc_q    <= step_acc;
      end
    end
  end

  assign dataIn     = data_q;
  assign regToWrite = wr_reg_q;
  assign regWrEnVec = wr_vec_q;
  assign regWrEnSc  = wr_sc_q;
  assign stateDbg   = state_q;
endmodule

// File: tb/tb_vec_execute_stage.sv
// Directed bench for vec_execute_stage: vector table for single-cycle ops plus
// hand-written back-to-back, multiply, and reset-during-multiply sequences.
module tb_vec_execute_stage;
  import vec_asip_pkg::*;

  logic        clk;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic [2:0]  opcode;
  logic [31:0] operand1, operand2, dataIn;
  logic [3:0]  destReg, regToWrite;
  logic        regWrEnVec, regWrEnSc, busy;
  state_e      stateDbg;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  dest;
    logic [31:0] exp_data;
    logic        exp_vec;
    logic        exp_sc;
  } vec_rec_t;

  vec_rec_t tbl[8];

  vec_execute_stage dut (
    .clk        (clk),
    .reset      (reset),
    .inValid    (inValid),
    .inReady    (inReady),
    .opcode     (opcode),
    .operand1   (operand1),
    .operand2   (operand2),
    .destReg    (destReg),
    .dataIn     (dataIn),
    .regToWrite (regToWrite),
    .regWrEnVec (regWrEnVec),
    .regWrEnSc  (regWrEnSc),
    .busy       (busy),
    .stateDbg   (stateDbg)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Advance to the next falling edge and run the write-port scoreboard.
  task tick();
    @(negedge clk);
    if (regWrEnVec && regWrEnSc) chk("one_hot_strobe", 32'd1, 32'd0);
    if (regWrEnVec || regWrEnSc) begin
      if (exp_q.size() == 0) chk("unexpected_strobe", 32'd1, 32'd0);
      else chk("sb_data", dataIn, exp_q.pop_front());
    end
  endtask

  task issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
             input logic [3:0] dest, input logic [31:0] exp, input logic expect_wr);
    inValid  = 1'b1;
    opcode   = op;
    operand1 = a;
    operand2 = b;
    destReg  = dest;
    if (expect_wr) exp_q.push_back(exp);
  endtask

  initial begin
    int strobes;
    tbl[0] = '{3'd0, 32'h01020304, 32'h10101010, 4'd3,  32'h11121314, 1'b1, 1'b0};
    tbl[1] = '{3'd0, 32'h00000003, 32'h00000001, 4'd4,  32'h00000004, 1'b0, 1'b1};
    tbl[2] = '{3'd2, 32'hF0F0AAAA, 32'h3C3CFF00, 4'd0,  32'h3030AA00, 1'b1, 1'b0};
    tbl[3] = '{3'd3, 32'h12345678, 32'h01020408, 4'd12, 32'h13365678, 1'b0, 1'b0};
    tbl[4] = '{3'd5, 32'h8101FF03, 32'h01070408, 4'd2,  32'h0280F003, 1'b1, 1'b0};
    tbl[5] = '{3'd6, 32'h80FF8110, 32'h0701030C, 4'd7,  32'h017F1001, 1'b0, 1'b1};
    tbl[6] = '{3'd4, 32'hFFFF0000, 32'h0F0F0F0F, 4'd5,  32'hF0F00F0F, 1'b0, 1'b1};
    tbl[7] = '{3'd1, 32'h00000005, 32'h01010101, 4'd1,  32'hFFFFFF04, 1'b1, 1'b0};

    reset = 1'b1; inValid = 1'b0; opcode = '0;
    operand1 = '0; operand2 = '0; destReg = '0;
    tick(); tick();
    chk("rst_dataIn", dataIn, 32'h0);
    chk("rst_regToWrite", 32'(regToWrite), 32'h0);
    chk("rst_strobes", {30'd0, regWrEnVec, regWrEnSc}, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_inReady", 32'(inReady), 32'h1);
    reset = 1'b0;
    tick();
    chk("post_rst_inReady", 32'(inReady), 32'h1);

    // Single-cycle ops, one at a time with an idle cycle between.
    for (int i = 0; i < 8; i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].dest, tbl[i].exp_data,
            tbl[i].exp_vec || tbl[i].exp_sc);
      tick();
      chk($sformatf("tbl%0d_data", i), dataIn, tbl[i].exp_data);
      chk($sformatf("tbl%0d_dest", i), 32'(regToWrite), 32'(tbl[i].dest));
      chk($sformatf("tbl%0d_vec", i), 32'(regWrEnVec), 32'(tbl[i].exp_vec));
      chk($sformatf("tbl%0d_sc", i), 32'(regWrEnSc), 32'(tbl[i].exp_sc));
      inValid = 1'b0;
      tick();
      chk($sformatf("tbl%0d_idle_strobes", i), {30'd0, regWrEnVec, regWrEnSc}, 32'h0);
      chk($sformatf("tbl%0d_ready", i), 32'(inReady), 32'h1);
      chk($sformatf("tbl%0d_hold", i), dataIn, tbl[i].exp_data);
    end

    // Back-to-back SUB then XOR.
    issue(3'd1, 32'h00000005, 32'h01010101, 4'd2, 32'hFFFFFF04, 1'b1);
    tick();
    chk("b2b_sub_data", dataIn, 32'hFFFFFF04);
    chk("b2b_sub_vec", 32'(regWrEnVec), 32'h1);
    chk("b2b_ready1", 32'(inReady), 32'h1);
    issue(3'd4, 32'hFFFF0000, 32'h0F0F0F0F, 4'd3, 32'hF0F00F0F, 1'b1);
    tick();
    chk("b2b_xor_data", dataIn, 32'hF0F00F0F);
    chk("b2b_xor_dest", 32'(regToWrite), 32'd3);
    chk("b2b_xor_vec", 32'(regWrEnVec), 32'h1);
    chk("b2b_ready2", 32'(inReady), 32'h1);
    inValid = 1'b0;
    tick();
    chk("b2b_idle_strobes", {30'd0, regWrEnVec, regWrEnSc}, 32'h0);

    // Multiply: 8 stall cycles, operands disturbed mid-flight, write on cycle 9.
    issue(3'd7, 32'h10020311, 32'h11030402, 4'd1, 32'h10060C22, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("mul_busy%0d", k), 32'(busy), 32'h1);
      chk($sformatf("mul_ready%0d", k), 32'(inReady), 32'h0);
      chk($sformatf("mul_state%0d", k), 32'(stateDbg), 32'(ST_MUL));
      chk($sformatf("mul_strobes%0d", k), {30'd0, regWrEnVec, regWrEnSc}, 32'h0);
      if (k == 1) begin
        opcode   = 3'd0;
        operand1 = $urandom();
        operand2 = $urandom();
        destReg  = 4'(32'($urandom_range(0, 15)));
      end
      if (k == 8) inValid = 1'b0;
    end
    tick();
    chk("mul_data", dataIn, 32'h10060C22);
    chk("mul_dest", 32'(regToWrite), 32'd1);
    chk("mul_vec", 32'(regWrEnVec), 32'h1);
    chk("mul_sc", 32'(regWrEnSc), 32'h0);
    chk("mul_done_busy", 32'(busy), 32'h0);
    chk("mul_done_ready", 32'(inReady), 32'h1);
    tick();
    chk("mul_after_strobes", {30'd0, regWrEnVec, regWrEnSc}, 32'h0);
    chk("mul_after_hold", dataIn, 32'h10060C22);

    // Reset three cycles into a multiply.
    issue(3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd2, 32'h0, 1'b0);
    tick();
    inValid = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("rmul_dataIn", dataIn, 32'h0);
    chk("rmul_regToWrite", 32'(regToWrite), 32'h0);
    chk("rmul_strobes", {30'd0, regWrEnVec, regWrEnSc}, 32'h0);
    chk("rmul_busy", 32'(busy), 32'h0);
    chk("rmul_ready", 32'(inReady), 32'h1);
    reset = 1'b0;
    strobes = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      strobes += int'(regWrEnVec) + int'(regWrEnSc);
    end
    chk("rmul_no_strobe", 32'(strobes), 32'h0);
    chk("rmul_ready_after", 32'(inReady), 32'h1);
    issue(3'd0, 32'h0A0B0C0D, 32'h01010101, 4'd0, 32'h0B0C0D0E, 1'b1);
    tick();
    chk("rmul_add_data", dataIn, 32'h0B0C0D0E);
    chk("rmul_add_vec", 32'(regWrEnVec), 32'h1);
    inValid = 1'b0;
    tick();

    chk("sb_empty", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
